pll_lock_rst_seq: RTL and testbench



---
 rtl/pll_lock_rst_seq.sv | 114 +++++++++++
 tb/tb_pll_lock_rst_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, qualifies LOCK, then releases
// peripheral and CPU resets in order. Lock timeout or loss restarts the PLL.
module pll_lock_rst_seq #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES      = 64,
    parameter int CNT_W               = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       periph_rstn,
    output logic       cpu_rstn,
    output logic       locked,
    output logic       lock_lost,
    output logic [7:0] relock_cnt
);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_REL_PERIPH,
        ST_RUN
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic                   relock_inc;
    logic                   lost_nxt;

    // pll_lock is asynchronous to clk; plain flop chain, reset to "unlocked"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_nxt  = state;
        relock_inc = 1'b0;
        lost_nxt   = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt  = ST_PLL_RST;
                    relock_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s)                 state_nxt = ST_WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_nxt = ST_REL_PERIPH;
            end
            ST_REL_PERIPH: begin
                // lock loss wins over the stagger exit
                if (!lock_s) begin
                    state_nxt  = ST_PLL_RST;
                    relock_inc = 1'b1;
                    lost_nxt   = 1'b1;
                end else if (cnt == STAGGER_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt  = ST_PLL_RST;
                    relock_inc = 1'b1;
                    lost_nxt   = 1'b1;
                end
            end
            default: state_nxt = ST_PLL_RST;
        endcase
    end

    // Outputs decode the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_PLL_RST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            periph_rstn <= 1'b0;
            cpu_rstn    <= 1'b0;
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
            relock_cnt  <= 8'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= (state_nxt != state || state_nxt == ST_RUN) ? '0 : cnt + 1'b1;
            pll_rst     <= (state_nxt == ST_PLL_RST);
            periph_rstn <= (state_nxt == ST_REL_PERIPH) || (state_nxt == ST_RUN);
            cpu_rstn    <= (state_nxt == ST_RUN);
            locked      <= (state_nxt == ST_RUN);
            lock_lost   <= lost_nxt;
            if (relock_inc && relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Randomised + directed bench for pll_lock_rst_seq against a phase/age model
// of the reset sequence, with literal cycle-accurate pins from the timing rules.
module tb_pll_lock_rst_seq;

    localparam int SYNC    = 2;
    localparam int PRST    = 4;
    localparam int TOUT    = 32;
    localparam int STAB    = 8;
    localparam int STAG    = 4;
    localparam int P_RST   = 0;
    localparam int P_WAIT  = 1;
    localparam int P_STAB  = 2;
    localparam int P_RELP  = 3;
    localparam int P_RUN   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_rst, periph_rstn, cpu_rstn, locked, lock_lost;
    logic [7:0] relock_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // model state: phase, first cycle of phase, restarts, lock_lost flag, sync history
    int            cyc;
    int            m_ph, m_t0, m_rc;
    bit            m_lost;
    logic [SYNC-1:0] m_hist;

    pll_lock_rst_seq #(
        .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(PRST), .LOCK_TIMEOUT_CYCLES(TOUT),
        .LOCK_STABLE_CYCLES(STAB), .STAGGER_CYCLES(STAG), .CNT_W(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .pll_rst(pll_rst),
        .periph_rstn(periph_rstn), .cpu_rstn(cpu_rstn), .locked(locked),
        .lock_lost(lock_lost), .relock_cnt(relock_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // at every edge, decide where the sequence goes from the age within the current phase
    always @(posedge clk or negedge rst_n) begin : model
        bit ls, inc, lost;
        int nph, age;
        if (!rst_n) begin
            cyc <= 0; m_ph <= P_RST; m_t0 <= 0; m_rc <= 0; m_lost <= 0; m_hist <= '0;
        end else begin
            ls = m_hist[SYNC-1];
            age = cyc - m_t0;
            nph = m_ph; inc = 0; lost = 0;
            if (m_ph == P_RST) begin
                if (age == PRST - 1) nph = P_WAIT;
            end else if (m_ph == P_WAIT) begin
                if (ls) nph = P_STAB;
                else if (age == TOUT - 1) begin nph = P_RST; inc = 1; end
            end else if (m_ph == P_STAB) begin
                if (!ls) nph = P_WAIT;
                else if (age == STAB - 1) nph = P_RELP;
            end else begin
                if (!ls) begin nph = P_RST; inc = 1; lost = 1; end
                else if (m_ph == P_RELP && age == STAG - 1) nph = P_RUN;
            end
            if (nph != m_ph) m_t0 <= cyc + 1;
            m_ph   <= nph;
            m_lost <= lost;
            if (inc && m_rc < 255) m_rc <= m_rc + 1;
            m_hist <= {m_hist[SYNC-2:0], pll_lock};
            cyc    <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("pll_rst", pll_rst, m_ph == P_RST);
            chk("periph_rstn", periph_rstn, m_ph >= P_RELP);
            chk("cpu_rstn", cpu_rstn, m_ph == P_RUN);
            chk("locked", locked, m_ph == P_RUN);
            chk("lock_lost", lock_lost, m_lost);
            chk("relock_cnt", relock_cnt, m_rc);
            chk("cpu_before_periph", cpu_rstn & ~periph_rstn, 0);
            chk("locked_eq_cpu", locked ^ cpu_rstn, 0);
        end
    end

    task automatic wait_cyc(input int n);
        int k = 0;
        while (cyc < n && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (cyc != n) begin
            n_chk++; n_fail++;
            $display("FAIL wait_cyc: reached cycle %0d, wanted %0d", cyc, n);
        end
    endtask

    // asynchronous reset pulse between edges; outputs must settle with no clock
    task automatic async_rst(input logic lock_val);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_periph_rstn", periph_rstn, 0);
        chk("rst_cpu_rstn", cpu_rstn, 0);
        chk("rst_locked", locked, 0);
        chk("rst_lock_lost", lock_lost, 0);
        chk("rst_relock_cnt", relock_cnt, 0);
        pll_lock = lock_val;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // clean power-up with lock tied high
        pll_lock = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_cyc(3);  chk("t1_pll_rst_c3", pll_rst, 1);
        wait_cyc(4);  chk("t1_pll_rst_c4", pll_rst, 0);
        wait_cyc(12); chk("t1_periph_c12", periph_rstn, 0);
        wait_cyc(13); chk("t1_periph_c13", periph_rstn, 1);
        wait_cyc(16); chk("t1_cpu_c16", cpu_rstn, 0);
        wait_cyc(17); chk("t1_cpu_c17", cpu_rstn, 1);
        chk("t1_locked_c17", locked, 1);
        chk("t1_relock_c17", relock_cnt, 0);

        // lock falls in RUN
        wait_cyc(30); pll_lock = 1'b0;
        wait_cyc(32); chk("t4_cpu_c32", cpu_rstn, 1);
        wait_cyc(33);
        chk("t4_pll_rst_c33", pll_rst, 1);
        chk("t4_lock_lost_c33", lock_lost, 1);
        chk("t4_periph_c33", periph_rstn, 0);
        chk("t4_relock_c33", relock_cnt, 1);
        wait_cyc(34); chk("t4_lock_lost_c34", lock_lost, 0);
        pll_lock = 1'b1;
        wait_cyc(49); chk("t4_cpu_c49", cpu_rstn, 0);
        wait_cyc(50); chk("t4_cpu_c50", cpu_rstn, 1);
        chk("t4_relock_c50", relock_cnt, 1);

        // reset mid-RUN, then lock tied low: timeouts and saturation
        wait_cyc(55);
        async_rst(1'b0);
        wait_cyc(35); chk("t2_pll_rst_c35", pll_rst, 0);
        wait_cyc(36); chk("t2_pll_rst_c36", pll_rst, 1);
        chk("t2_relock_c36", relock_cnt, 1);
        wait_cyc(39); chk("t2_pll_rst_c39", pll_rst, 1);
        wait_cyc(40); chk("t2_pll_rst_c40", pll_rst, 0);
        wait_cyc(9179); chk("t2_relock_c9179", relock_cnt, 254);
        wait_cyc(9180); chk("t2_relock_c9180", relock_cnt, 255);
        wait_cyc(9300); chk("t2_relock_sat", relock_cnt, 255);

        // one-cycle lock glitch during STABLE
        async_rst(1'b1);
        wait_cyc(6); pll_lock = 1'b0;
        wait_cyc(7); pll_lock = 1'b1;
        wait_cyc(13); chk("t3_periph_c13", periph_rstn, 0);
        wait_cyc(17); chk("t3_periph_c17", periph_rstn, 0);
        wait_cyc(18); chk("t3_periph_c18", periph_rstn, 1);
        wait_cyc(21); chk("t3_cpu_c21", cpu_rstn, 0);
        wait_cyc(22); chk("t3_cpu_c22", cpu_rstn, 1);
        chk("t3_relock", relock_cnt, 0);

        // lock lost on the stagger-exit cycle
        async_rst(1'b1);
        wait_cyc(14); pll_lock = 1'b0;
        wait_cyc(16);
        chk("t5_periph_c16", periph_rstn, 1);
        chk("t5_cpu_c16", cpu_rstn, 0);
        wait_cyc(17);
        chk("t5_pll_rst_c17", pll_rst, 1);
        chk("t5_lock_lost_c17", lock_lost, 1);
        chk("t5_periph_c17", periph_rstn, 0);
        chk("t5_relock_c17", relock_cnt, 1);
        pll_lock = 1'b1;
        for (int c = 18; c <= 30; c++) begin
            wait_cyc(c);
            chk("t5_cpu_held", cpu_rstn, 0);
        end

        // random lock behaviour with occasional async resets
        async_rst(1'b1);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 999) == 0) begin
                async_rst(1'($urandom_range(0, 1)));
            end else if (pll_lock) begin
                if ($urandom_range(0, 59) == 0) pll_lock = 1'b0;
            end else begin
                if ($urandom_range(0, 7) == 0) pll_lock = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
